// File: rtl/bp_me_pkg.sv
// Shared types for the CCE-to-DMA bridge: message layouts, DMA packet and bridge FSM states.
// The message structs mirror the layouts the BlackParrot/bsg macros expand to for this config.
package bp_me_pkg;

    localparam int paddr_width_p     = 40;
    localparam int cce_block_width_p = 512;
    localparam int dword_width_p     = 64;
    localparam int lce_id_width_p    = 4;
    localparam int lce_assoc_p       = 8;

    localparam int block_size_in_words_lp = cce_block_width_p / dword_width_p;
    localparam int block_offset_width_lp  = $clog2(cce_block_width_p / 8);
    localparam int beat_cnt_width_lp      = $clog2(block_size_in_words_lp);
    localparam logic [beat_cnt_width_lp-1:0] last_beat_lp =
        beat_cnt_width_lp'(block_size_in_words_lp - 1);

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011,
        e_cce_mem_pre   = 4'b0100
    } bp_cce_mem_cmd_type_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]      lce_id;
        logic [$clog2(lce_assoc_p)-1:0] way_id;
        logic [2:0]                     state;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [2:0]                size;
        bp_cce_mem_payload_s       payload;
        logic [paddr_width_p-1:0]  addr;
        logic [3:0]                msg_type;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_cce_mem_msg_header_s       header;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef struct packed {
        logic                     write_not_read;
        logic [paddr_width_p-1:0] addr;
    } bsg_cache_dma_pkt_s;

    localparam int bsg_cache_dma_pkt_width_lp = $bits(bsg_cache_dma_pkt_s);

    typedef enum logic [2:0] {
        e_dma_reset,
        e_dma_ready,
        e_dma_send_pkt,
        e_dma_send_data,
        e_dma_recv_data,
        e_dma_send_resp
    } bp_me_dma_state_e;

    // Everything that is not an explicit (cached or uncached) write is serviced as a read.
    function automatic logic is_write(input logic [3:0] msg_type);
        return (msg_type == e_cce_mem_wr) || (msg_type == e_cce_mem_uc_wr);
    endfunction

endpackage

// File: rtl/bp_me_dma_beat_sipo.sv
// Collects block_size_in_words_lp dword beats into a block buffer, word 0 first.
// done_o pulses combinationally with the handshake of the final beat.
module bp_me_dma_beat_sipo
    import bp_me_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    input  logic [dword_width_p-1:0]     data_i,
    input  logic                         v_i,
    output logic                         ready_o,
    output logic [cce_block_width_p-1:0] data_o,
    output logic                         done_o
);

    logic [beat_cnt_width_lp-1:0] count_q, count_d;
    logic [block_size_in_words_lp-1:0][dword_width_p-1:0] buf_q;
    logic fire;

    assign ready_o = en_i;
    assign fire    = en_i & v_i;
    assign done_o  = fire & (count_q == last_beat_lp);
    assign data_o  = buf_q;

    always_comb begin
        count_d = count_q;
        if (fire) begin
            count_d = (count_q == last_beat_lp) ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; the buffer is
    // cleared on reset as well so no stale block can ever be observed after an abort.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            buf_q   <= '0;
        end else begin
            count_q <= count_d;
            if (fire) begin
                buf_q[count_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/bp_me_cce_to_cache_dma.sv
// Responder bridge: replays block CCE memory commands on a bsg_cache DMA interface.
// Optional BP_ME_CCE_TO_DMA_CMD_FIFO_EN adds a two-entry command FIFO ahead of the FSM.
module bp_me_cce_to_cache_dma
    import bp_me_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic [cce_mem_msg_width_lp-1:0]       mem_cmd_i,
    input  logic                                  mem_cmd_v_i,
    output logic                                  mem_cmd_ready_o,

    output logic [cce_mem_msg_width_lp-1:0]       mem_resp_o,
    output logic                                  mem_resp_v_o,
    input  logic                                  mem_resp_yumi_i,

    output logic [bsg_cache_dma_pkt_width_lp-1:0] dma_pkt_o,
    output logic                                  dma_pkt_v_o,
    input  logic                                  dma_pkt_yumi_i,

    output logic [dword_width_p-1:0]              dma_data_o,
    output logic                                  dma_data_v_o,
    input  logic                                  dma_data_yumi_i,

    input  logic [dword_width_p-1:0]              dma_data_i,
    input  logic                                  dma_data_v_i,
    output logic                                  dma_data_ready_o
);

    bp_me_dma_state_e state_q, state_d;
    bp_cce_mem_msg_s  cmd_q, cmd_d;
    logic [beat_cnt_width_lp-1:0] wr_cnt_q, wr_cnt_d;

    logic                            cmd_v;
    logic                            cmd_deq;
    logic [cce_mem_msg_width_lp-1:0] cmd_data;
    logic                            sipo_en;
    logic                            sipo_done;
    logic [cce_block_width_p-1:0]    sipo_data;
    logic                            cmd_is_write;
    logic [block_size_in_words_lp-1:0][dword_width_p-1:0] wr_words;
    bsg_cache_dma_pkt_s              pkt;
    bp_cce_mem_msg_s                 resp;

`ifdef BP_ME_CCE_TO_DMA_CMD_FIFO_EN
    logic [1:0][cce_mem_msg_width_lp-1:0] fifo_mem_q;
    logic                                 fifo_rd_q;
    logic [1:0]                           fifo_cnt_q;
    logic                                 fifo_enq;

    assign mem_cmd_ready_o = (state_q != e_dma_reset) && (fifo_cnt_q != 2'd2);
    assign fifo_enq        = mem_cmd_v_i & mem_cmd_ready_o;
    assign cmd_v           = (fifo_cnt_q != 2'd0);
    assign cmd_data        = fifo_mem_q[fifo_rd_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fifo_mem_q <= '0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            // Write slot is the head when empty, the other slot when one entry is held.
            if (fifo_enq) begin
                fifo_mem_q[fifo_rd_q ^ fifo_cnt_q[0]] <= mem_cmd_i;
            end
            if (cmd_deq) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_enq} - {1'b0, cmd_deq};
        end
    end
`else
    assign mem_cmd_ready_o = (state_q == e_dma_ready);
    assign cmd_v           = mem_cmd_v_i;
    assign cmd_data        = mem_cmd_i;
`endif

    assign cmd_is_write = is_write(cmd_q.header.msg_type);
    assign wr_words     = cmd_q.data;
    assign sipo_en      = (state_q == e_dma_recv_data);

    assign pkt = '{
        write_not_read: cmd_is_write,
        addr:           {cmd_q.header.addr[paddr_width_p-1:block_offset_width_lp],
                         {block_offset_width_lp{1'b0}}}
    };
    assign resp = '{
        data:   cmd_is_write ? {cce_block_width_p{1'b0}} : sipo_data,
        header: cmd_q.header
    };

    assign dma_pkt_o  = pkt;
    assign dma_data_o = wr_words[wr_cnt_q];
    assign mem_resp_o = resp;

    bp_me_dma_beat_sipo u_sipo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (sipo_en),
        .data_i  (dma_data_i),
        .v_i     (dma_data_v_i),
        .ready_o (dma_data_ready_o),
        .data_o  (sipo_data),
        .done_o  (sipo_done)
    );

    // NOTE: every output of this block is given a default up front so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        wr_cnt_d     = wr_cnt_q;
        cmd_deq      = 1'b0;
        dma_pkt_v_o  = 1'b0;
        dma_data_v_o = 1'b0;
        mem_resp_v_o = 1'b0;

        case (state_q)
            e_dma_reset: state_d = e_dma_ready;
            e_dma_ready: begin
                if (cmd_v) begin
                    cmd_d   = cmd_data;
                    cmd_deq = 1'b1;
                    state_d = e_dma_send_pkt;
                end
            end
            e_dma_send_pkt: begin
                dma_pkt_v_o = 1'b1;
                if (dma_pkt_yumi_i) begin
                    state_d = cmd_is_write ? e_dma_send_data : e_dma_recv_data;
                end
            end
            e_dma_send_data: begin
                dma_data_v_o = 1'b1;
                if (dma_data_yumi_i) begin
                    if (wr_cnt_q == last_beat_lp) begin
                        wr_cnt_d = '0;
                        state_d  = e_dma_send_resp;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            e_dma_recv_data: begin
                if (sipo_done) begin
                    state_d = e_dma_send_resp;
                end
            end
            e_dma_send_resp: begin
                mem_resp_v_o = 1'b1;
                if (mem_resp_yumi_i) begin
                    state_d = e_dma_ready;
                end
            end
            default: state_d = e_dma_reset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= e_dma_reset;
            cmd_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_me_cce_to_cache_dma.sv
// Scoreboard bench for bp_me_cce_to_cache_dma: expectations are queued when a command is
// issued and popped as the DUT emits packets, write beats and responses.
module tb_bp_me_cce_to_cache_dma;
    import bp_me_pkg::*;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    logic [cce_mem_msg_width_lp-1:0]       mem_cmd_i       = '0;
    logic                                  mem_cmd_v_i     = 1'b0;
    logic                                  mem_cmd_ready_o;
    logic [cce_mem_msg_width_lp-1:0]       mem_resp_o;
    logic                                  mem_resp_v_o;
    logic                                  mem_resp_yumi_i = 1'b0;
    logic [bsg_cache_dma_pkt_width_lp-1:0] dma_pkt_o;
    logic                                  dma_pkt_v_o;
    logic                                  dma_pkt_yumi_i  = 1'b0;
    logic [dword_width_p-1:0]              dma_data_o;
    logic                                  dma_data_v_o;
    logic                                  dma_data_yumi_i = 1'b0;
    logic [dword_width_p-1:0]              dma_data_i      = '0;
    logic                                  dma_data_v_i    = 1'b0;
    logic                                  dma_data_ready_o;

    always #5 clk_i = ~clk_i;

    bp_me_cce_to_cache_dma dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_yumi_i (mem_resp_yumi_i),
        .dma_pkt_o       (dma_pkt_o),
        .dma_pkt_v_o     (dma_pkt_v_o),
        .dma_pkt_yumi_i  (dma_pkt_yumi_i),
        .dma_data_o      (dma_data_o),
        .dma_data_v_o    (dma_data_v_o),
        .dma_data_yumi_i (dma_data_yumi_i),
        .dma_data_i      (dma_data_i),
        .dma_data_v_i    (dma_data_v_i),
        .dma_data_ready_o(dma_data_ready_o)
    );

    int checks   = 0;
    int failures = 0;

    bsg_cache_dma_pkt_s       exp_pkt_q[$];
    logic [dword_width_p-1:0] exp_wbeat_q[$];
    logic [dword_width_p-1:0] rd_beat_q[$];
    bp_cce_mem_msg_s          exp_resp_q[$];
    bit                       early_accepted;

`ifdef BP_ME_CCE_TO_DMA_CMD_FIFO_EN
    localparam int exp_lat_lp = 10;
`else
    localparam int exp_lat_lp = 9;
`endif

    function automatic logic [cce_block_width_p-1:0] make_block(input logic [dword_width_p-1:0] base);
        logic [cce_block_width_p-1:0] b;
        for (int i = 0; i < block_size_in_words_lp; i++) b[i*dword_width_p +: dword_width_p] = base + dword_width_p'(i);
        return b;
    endfunction

    function automatic logic [cce_block_width_p-1:0] rand_block();
        logic [cce_block_width_p-1:0] b;
        for (int i = 0; i < cce_block_width_p / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    function automatic bp_cce_mem_msg_s make_cmd(input logic [3:0] t, input logic [paddr_width_p-1:0] a,
                                                 input logic [cce_block_width_p-1:0] d);
        bp_cce_mem_msg_s m;
        m.header.msg_type = t;
        m.header.addr     = a;
        m.header.payload  = bp_cce_mem_payload_s'(10'($urandom()));
        m.header.size     = 3'd6;
        m.data            = d;
        return m;
    endfunction

    task automatic push_expect(input bp_cce_mem_msg_s cmd, input logic [cce_block_width_p-1:0] rd_block);
        bsg_cache_dma_pkt_s p;
        bp_cce_mem_msg_s    r;
        logic               w;
        w = (cmd.header.msg_type == 4'h1) || (cmd.header.msg_type == 4'h3);
        p.write_not_read = w;
        p.addr           = cmd.header.addr & ~40'h3F;
        exp_pkt_q.push_back(p);
        for (int i = 0; i < 8; i++) begin
            if (w) exp_wbeat_q.push_back(cmd.data[i*64 +: 64]);
            else   rd_beat_q.push_back(rd_block[i*64 +: 64]);
        end
        r.header = cmd.header;
        r.data   = w ? '0 : rd_block;
        exp_resp_q.push_back(r);
    endtask

    task automatic issue(input bp_cce_mem_msg_s cmd);
        logic rdy;
        int   cyc = 0;
        mem_cmd_i   = cmd;
        mem_cmd_v_i = 1'b1;
        while (1) begin
            rdy = mem_cmd_ready_o;
            @(negedge clk_i);
            if (rdy) break;
            cyc++;
            if (cyc > 100) begin
                checks++; failures++;
                $display("FAIL cmd_accept: no ready within %0d cycles, required acceptance", cyc);
                break;
            end
        end
        mem_cmd_v_i = 1'b0;
    endtask

    function automatic logic go(input int stall_pct);
        return $urandom_range(99) >= stall_pct;
    endfunction

    // Runs at negedges until n_resp responses are consumed; abort_at >= 0 asserts reset while
    // that read beat index is being offered.
    task automatic service(input int n_resp, input int stall_pct, input int abort_at,
                           input int resp_hold, input bit check_blocked, output int first_resp_cyc);
        int   got = 0, cyc = 0, rd_idx = 0, held = 0;
        bit   fire_pending = 0, resp_pending = 0;
        logic [4:0] vs;
        first_resp_cyc = -1;
        while (got < n_resp) begin
            if (fire_pending) begin
                mem_cmd_v_i = 1'b0; fire_pending = 0; early_accepted = 1;
            end
            if (abort_at >= 0 && rd_idx == abort_at && dma_data_ready_o) begin
                reset_i = 1'b1; dma_data_v_i = 1'b1; dma_data_i = rd_beat_q[0];
                dma_pkt_yumi_i = 0; dma_data_yumi_i = 0; mem_resp_yumi_i = 0;
                @(negedge clk_i);
                vs = {mem_cmd_ready_o, mem_resp_v_o, dma_pkt_v_o, dma_data_v_o, dma_data_ready_o};
                checks++;
                if (vs !== 5'b0) begin
                    failures++; $display("FAIL abort_valids: got %b required 00000", vs);
                end
                reset_i = 1'b0; dma_data_v_i = 1'b0;
                exp_pkt_q.delete(); exp_wbeat_q.delete(); rd_beat_q.delete(); exp_resp_q.delete();
                @(negedge clk_i);
                return;
            end
            // packet channel
            if (dma_pkt_v_o) begin
                checks++;
                if (exp_pkt_q.size() == 0) begin
                    failures++; $display("FAIL pkt: got %h required none", dma_pkt_o);
                end else if (dma_pkt_o !== exp_pkt_q[0]) begin
                    failures++; $display("FAIL pkt: got %h required %h", dma_pkt_o, exp_pkt_q[0]);
                end
            end
            dma_pkt_yumi_i = dma_pkt_v_o && go(stall_pct);
            if (dma_pkt_yumi_i && exp_pkt_q.size() > 0) void'(exp_pkt_q.pop_front());
            // write beat channel
            if (dma_data_v_o) begin
                checks++;
                if (exp_wbeat_q.size() == 0) begin
                    failures++; $display("FAIL wbeat: got %h required none", dma_data_o);
                end else if (dma_data_o !== exp_wbeat_q[0]) begin
                    failures++; $display("FAIL wbeat: got %h required %h", dma_data_o, exp_wbeat_q[0]);
                end
            end
            dma_data_yumi_i = dma_data_v_o && go(stall_pct);
            if (dma_data_yumi_i && exp_wbeat_q.size() > 0) void'(exp_wbeat_q.pop_front());
            // read beat channel: offered whenever data is queued, even outside RECV_DATA
            dma_data_v_i = (rd_beat_q.size() > 0) && go(stall_pct);
            dma_data_i   = dma_data_v_i ? rd_beat_q[0] : {$urandom(), $urandom()};
            if (dma_data_v_i && dma_data_ready_o) begin
                void'(rd_beat_q.pop_front()); rd_idx++;
            end
            // response channel
            if (resp_pending) begin
                checks++;
                if (mem_resp_v_o !== 1'b1) begin
                    failures++; $display("FAIL resp_held: got v=%b required 1", mem_resp_v_o);
                end
            end
            if (mem_resp_v_o) begin
                if (first_resp_cyc < 0) first_resp_cyc = cyc;
                checks++;
                if (exp_resp_q.size() == 0) begin
                    failures++; $display("FAIL resp: got %h required none", mem_resp_o);
                end else if (mem_resp_o !== exp_resp_q[0]) begin
                    failures++; $display("FAIL resp: got %h required %h", mem_resp_o, exp_resp_q[0]);
                end
                checks++;
                if ({dma_pkt_v_o, dma_data_v_o} !== 2'b00) begin
                    failures++; $display("FAIL resp_excl: got pkt_v/data_v=%b%b required 00", dma_pkt_v_o, dma_data_v_o);
                end
                if (held < resp_hold) begin
                    mem_resp_yumi_i = 1'b0; held++;
                end else begin
                    mem_resp_yumi_i = go(stall_pct);
                end
                resp_pending = !mem_resp_yumi_i;
                if (mem_resp_yumi_i) begin
                    if (exp_resp_q.size() > 0) void'(exp_resp_q.pop_front());
                    got++;
                end
            end else begin
                mem_resp_yumi_i = 1'b0;
            end
            // second command presented while this transaction is in flight
            if (check_blocked && mem_cmd_v_i) begin
`ifdef BP_ME_CCE_TO_DMA_CMD_FIFO_EN
                if (mem_cmd_ready_o) fire_pending = 1;
`else
                checks++;
                if (mem_cmd_ready_o !== 1'b0) begin
                    failures++; $display("FAIL cmd_blocked: got ready=%b required 0", mem_cmd_ready_o);
                end
`endif
            end
            @(negedge clk_i);
            cyc++;
            if (cyc > 2000) begin
                checks++; failures++;
                $display("FAIL service_timeout: got %0d responses required %0d", got, n_resp);
                break;
            end
        end
        if (fire_pending) begin
            mem_cmd_v_i = 1'b0; early_accepted = 1;
        end
        dma_pkt_yumi_i = 0; dma_data_yumi_i = 0; mem_resp_yumi_i = 0; dma_data_v_i = 0;
    endtask

    task automatic test_reset();
        logic [4:0] vs;
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        vs = {mem_cmd_ready_o, mem_resp_v_o, dma_pkt_v_o, dma_data_v_o, dma_data_ready_o};
        checks++;
        if (vs !== 5'b0) begin
            failures++; $display("FAIL reset_outputs: got %b required 00000", vs);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset: got %b required 1", mem_cmd_ready_o);
        end
    endtask

    task automatic run_one(input bp_cce_mem_msg_s cmd, input logic [cce_block_width_p-1:0] blk,
                           input int stall_pct, input bit check_lat, input string name);
        int lat;
        push_expect(cmd, blk);
        issue(cmd);
        service(1, stall_pct, -1, 0, 0, lat);
        if (check_lat) begin
            checks++;
            if (lat !== exp_lat_lp) begin
                failures++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat_lp);
            end
        end
    endtask

    task automatic test_read();
        run_one(make_cmd(4'h0, 40'h00_8000_0048, rand_block()), make_block(64'h0), 0, 1, "read");
    endtask

    task automatic test_write();
        run_one(make_cmd(4'h1, 40'h00_8000_0100, make_block(64'hA0)), '0, 0, 1, "write");
    endtask

    task automatic test_other_types();
        run_one(make_cmd(4'h4, 40'h00_1234_567F, rand_block()), rand_block(), 0, 0, "pre");
        run_one(make_cmd(4'h2, 40'h00_0000_003F, rand_block()), rand_block(), 0, 0, "uc_rd");
        run_one(make_cmd(4'h3, 40'hFF_FFFF_FFC1, rand_block()), '0, 0, 0, "uc_wr");
    endtask

    task automatic test_stall();
        logic [3:0] types [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        for (int k = 0; k < 6; k++) begin
            run_one(make_cmd(types[k], paddr_width_p'({$urandom(), $urandom()}), rand_block()),
                    rand_block(), 50, 0, "stall");
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bp_cce_mem_msg_s c;
        c = make_cmd(4'h0, 40'h00_4000_0080, rand_block());
        push_expect(c, make_block(64'h1111_0000));
        issue(c);
        service(1, 0, 3, 0, 0, lat);
        run_one(make_cmd(4'h0, 40'h00_4000_00C8, rand_block()), make_block(64'h2222_0000), 0, 1, "post_reset");
    endtask

    task automatic test_back_to_back();
        int lat;
        bp_cce_mem_msg_s wr, rd;
        wr = make_cmd(4'h1, 40'h00_8000_0200, make_block(64'hB0));
        rd = make_cmd(4'h0, 40'h00_8000_0208, rand_block());
        push_expect(wr, '0);
        issue(wr);
        push_expect(rd, make_block(64'hC0));
        mem_cmd_i      = rd;
        mem_cmd_v_i    = 1'b1;
        early_accepted = 0;
        service(1, 0, -1, 0, 1, lat);
`ifdef BP_ME_CCE_TO_DMA_CMD_FIFO_EN
        checks++;
        if (early_accepted !== 1'b1) begin
            failures++; $display("FAIL early_accept: got %b required 1", early_accepted);
        end
        mem_cmd_v_i = 1'b0;
`else
        issue(rd);
`endif
        service(1, 0, -1, 0, 0, lat);
    endtask

    task automatic test_resp_hold();
        int lat;
        bp_cce_mem_msg_s c;
        c = make_cmd(4'h0, 40'h00_9000_0010, rand_block());
        push_expect(c, rand_block());
        issue(c);
        service(1, 0, -1, 10, 0, lat);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_other_types();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_resp_hold();
        checks++;
        if (exp_pkt_q.size() + exp_wbeat_q.size() + rd_beat_q.size() + exp_resp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d/%0d/%0d left required 0/0/0/0",
                     exp_pkt_q.size(), exp_wbeat_q.size(), rd_beat_q.size(), exp_resp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
